// File: rtl/alu_seq.sv
// Registered ALU with iterative shift-add multiply and N/Z/P flags.
// Result register drives the shared datapath bus through a tri-state gate.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             busy,
  input  logic             gate_alu,
  output logic [WIDTH-1:0] alu_bus
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    cnt, sh;
  logic             accept, mul_go, mul_last;

  function automatic logic [2:0] flags(
    input logic [WIDTH-1:0] r
  );
    if (r[WIDTH-1])   return 3'b100;
    else if (r == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign sh       = B[SW-1:0];
  assign accept   = start && (state == IDLE);
  assign mul_go   = accept && MUL_EN && (op == 3'b111);
  assign mul_last = (state == MUL) && (&cnt);
  assign acc_nxt  = acc + (b_q[cnt] ? (a_q << cnt) : '0);

  always_comb begin
    alu_res = '0;
    unique case (op)
      3'b000: alu_res = A + B;
      3'b001: alu_res = A & B;
      3'b010: alu_res = ~A;
      3'b011: alu_res = A;
      3'b100: alu_res = A - B;
      3'b101: alu_res = A << sh;
      3'b110: alu_res = $signed(A) >>> sh;
      3'b111: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (mul_go)   state_nxt = MUL;
      MUL:  if (mul_last) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == MUL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      nzp       <= 3'b010;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !mul_go) begin
        result    <= alu_res;
        nzp       <= flags(alu_res);
        out_valid <= 1'b1;
      end
      if (mul_go) begin
        a_q <= A;
        b_q <= B;
        acc <= '0;
        cnt <= '0;
      end
      if (state == MUL) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        // last step folds straight into the result register
        if (mul_last) begin
          result    <= acc_nxt;
          nzp       <= flags(acc_nxt);
          out_valid <= 1'b1;
        end
      end
    end
  end

  assign alu_bus = gate_alu ? result : {WIDTH{1'bz}};

endmodule
